float_compare_pipe: RTL and testbench

- Parametrised, pipelined sign-magnitude floating-point comparator with selectable compare mode and valid/ready handshake on both sides.
- Generalises the combinational greater-than block to configurable widths and four compare ops.
- Also tracks the running maximum of operand A over a stream and counts true results.
- Sits between operand producers and any sort or threshold logic that needs registered, back-pressurable compare results.

---
 rtl/float_compare_pipe.sv | 165 ++++++++++++++++
 tb/tb_float_compare_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_compare_pipe.sv
// Two-stage pipelined sign-magnitude float comparator (GT/LT/EQ/GE) with valid/ready
// handshake, running max of operand A and a saturating true-result counter.
// Optional build macro FLOAT_CMP_ZERO_EQ_EN makes +0 and -0 compare equal.
module float_compare_pipe #(
  parameter int unsigned EXP_W  = 4,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res,
  output logic [W-1:0]     out_a,
  input  logic             max_clr,
  output logic             max_valid,
  output logic [W-1:0]     max_val,
  output logic [CNT_W-1:0] true_cnt
);

  localparam int unsigned MagW = EXP_W + FRAC_W;

  // Returns {greater, equal} for A vs B from pre-decoded sign/magnitude facts.
  function automatic logic [1:0] order(input logic sa, input logic sb, input logic mgt,
                                       input logic meq, input logic both_zero);
    logic greater;
    logic equal;
    greater = 1'b0;
    equal   = 1'b0;
    if (sa != sb) begin
      greater = !sa;
    end else begin
      greater = sa ? (!mgt && !meq) : mgt;
      equal   = meq;
    end
    if (both_zero) begin
      greater = 1'b0;
      equal   = 1'b1;
    end
    return {greater, equal};
  endfunction

  logic             rdy_q;
  logic             s1_valid_q;
  logic             s1_sa_q, s1_sb_q;
  logic [1:0]       s1_op_q;
  logic [W-1:0]     s1_a_q;
  logic             s1_mgt_q, s1_meq_q;
  logic             out_valid_q, res_q;
  logic [W-1:0]     out_a_q;
  logic             max_valid_q;
  logic [W-1:0]     max_val_q;
  logic [CNT_W-1:0] true_cnt_q;

  logic adv;
  logic accept;
  logic s1_bz;
  logic s1_res;
  logic max_bz;
  logic max_upd;

  assign adv    = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;

  assign in_ready  = rdy_q && adv;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign out_a     = out_a_q;
  assign max_valid = max_valid_q;
  assign max_val   = max_val_q;
  assign true_cnt  = true_cnt_q;

`ifdef FLOAT_CMP_ZERO_EQ_EN
  logic s1_za_q, s1_zb_q;
  assign s1_bz  = s1_za_q && s1_zb_q;
  assign max_bz = (s1_a_q[MagW-1:0] == '0) && (max_val_q[MagW-1:0] == '0);
`else
  assign s1_bz  = 1'b0;
  assign max_bz = 1'b0;
`endif

  always_comb begin
    logic [1:0] ge;
    ge     = order(s1_sa_q, s1_sb_q, s1_mgt_q, s1_meq_q, s1_bz);
    s1_res = 1'b0;
    unique case (s1_op_q)
      2'b00:   s1_res = ge[1];
      2'b01:   s1_res = !ge[1] && !ge[0];
      2'b10:   s1_res = ge[0];
      default: s1_res = ge[1] || ge[0];
    endcase
  end

  // Equal values never rewrite the stored max, so only strict "greater" updates it.
  always_comb begin
    logic [1:0] mo;
    mo      = order(s1_a_q[W-1], max_val_q[W-1],
                    s1_a_q[MagW-1:0] > max_val_q[MagW-1:0],
                    s1_a_q[MagW-1:0] == max_val_q[MagW-1:0], max_bz);
    max_upd = !max_valid_q || mo[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sa_q     <= 1'b0;
      s1_sb_q     <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_a_q      <= '0;
      s1_mgt_q    <= 1'b0;
      s1_meq_q    <= 1'b0;
`ifdef FLOAT_CMP_ZERO_EQ_EN
      s1_za_q     <= 1'b0;
      s1_zb_q     <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      res_q       <= 1'b0;
      out_a_q     <= '0;
      max_valid_q <= 1'b0;
      max_val_q   <= '0;
      true_cnt_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_sa_q  <= a[W-1];
          s1_sb_q  <= b[W-1];
          s1_op_q  <= op;
          s1_a_q   <= a;
          s1_mgt_q <= a[MagW-1:0] > b[MagW-1:0];
          s1_meq_q <= a[MagW-1:0] == b[MagW-1:0];
`ifdef FLOAT_CMP_ZERO_EQ_EN
          s1_za_q  <= a[MagW-1:0] == '0;
          s1_zb_q  <= b[MagW-1:0] == '0;
`endif
        end
        out_valid_q <= s1_valid_q;
        res_q       <= s1_res;
        out_a_q     <= s1_a_q;
      end
      if (max_clr) begin
        max_valid_q <= 1'b0;
        max_val_q   <= '0;
        true_cnt_q  <= '0;
      end else begin
        if (adv && s1_valid_q && max_upd) begin
          max_valid_q <= 1'b1;
          max_val_q   <= s1_a_q;
        end
        if (out_valid_q && out_ready && res_q && !(&true_cnt_q)) begin
          true_cnt_q <= true_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_float_compare_pipe.sv
// Scoreboard bench for float_compare_pipe: directed vectors push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_float_compare_pipe;

  localparam int W = 13;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, res, max_clr, max_valid;
  logic [1:0]    op;
  logic [W-1:0]  a, b, out_a, max_val;
  logic [15:0]   true_cnt;

  int errs   = 0;
  int checks = 0;
  logic [W:0] sb_q[$];
  logic [W:0] mon_e;

  localparam logic [1:0] GT = 2'b00, LT = 2'b01, EQ = 2'b10, GE = 2'b11;

  always #5 clk = ~clk;

  float_compare_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .out_a     (out_a),
    .max_clr   (max_clr),
    .max_valid (max_valid),
    .max_val   (max_val),
    .true_cnt  (true_cnt)
  );

  function automatic logic [W-1:0] f(input logic s, input logic [3:0] e, input logic [7:0] m);
    return {s, e, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic r);
    int n;
    n = 0;
    in_valid = 1'b1;
    op = o;
    a  = xa;
    b  = xb;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end else begin
      sb_q.push_back({r, xa});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: pending got %0d want 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result: got out_a %0h want no result", out_a);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res", {31'd0, res}, {31'd0, mon_e[W]});
        chk("out_a", {19'd0, out_a}, {19'd0, mon_e[W-1:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got limit want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; max_clr = 1'b0;
    op = GT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_res", {31'd0, res}, 0);
    chk("rst_out_a", {19'd0, out_a}, 0);
    chk("rst_max_valid", {31'd0, max_valid}, 0);
    chk("rst_max_val", {19'd0, max_val}, 0);
    chk("rst_true_cnt", {16'd0, true_cnt}, 0);
    @(posedge clk);
    #1 chk("in_ready_after_rst", {31'd0, in_ready}, 1);

    // Basic ordering across signs and ops
    send(GT, f(0, 3, 8'h87), f(0, 3, 8'h97), 1'b0);
    send(LT, f(0, 3, 8'h87), f(0, 3, 8'h97), 1'b1);
    send(GT, f(1, 4, 8'h48), f(0, 3, 8'h31), 1'b0);
    send(GT, f(1, 6, 8'h57), f(1, 6, 8'h45), 1'b0);
    send(GE, f(0, 5, 8'h12), f(0, 5, 8'h12), 1'b1);
    send(EQ, f(0, 5, 8'h12), f(0, 5, 8'h12), 1'b1);
    drain();
    chk("cnt_basic", {16'd0, true_cnt}, 3);
    chk("max_basic", {19'd0, max_val}, {19'd0, f(0, 5, 8'h12)});

    // Running max over a stream after a clear
    max_clr = 1'b1;
    @(posedge clk);
    #1 max_clr = 1'b0;
    chk("clr_cnt", {16'd0, true_cnt}, 0);
    chk("clr_max_valid", {31'd0, max_valid}, 0);
    send(GT, f(0, 3, 8'h10), f(0, 4, 8'h00), 1'b0);
    send(GT, f(1, 7, 8'hFF), f(0, 4, 8'h00), 1'b0);
    send(GT, f(0, 5, 8'h01), f(0, 4, 8'h00), 1'b1);
    send(GT, f(0, 4, 8'hFF), f(0, 4, 8'h00), 1'b1);
    drain();
    chk("stream_max_val", {19'd0, max_val}, {19'd0, f(0, 5, 8'h01)});
    chk("stream_max_valid", {31'd0, max_valid}, 1);
    chk("stream_cnt", {16'd0, true_cnt}, 2);

    // Backpressure: three beats offered while the consumer stalls
    out_ready = 1'b0;
    fork
      begin
        send(GT, f(0, 2, 8'h01), f(0, 1, 8'h00), 1'b1);
        send(GT, f(0, 1, 8'h00), f(0, 2, 8'h01), 1'b0);
        send(GT, f(1, 1, 8'h00), f(1, 2, 8'h00), 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_out_a_early", {19'd0, out_a}, {19'd0, f(0, 2, 8'h01)});
        repeat (2) @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        chk("stall_out_a", {19'd0, out_a}, {19'd0, f(0, 2, 8'h01)});
        chk("stall_res", {31'd0, res}, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cnt", {16'd0, true_cnt}, 4);

    // max_clr on the same edge as a true-result handshake
    send(GT, f(0, 5, 8'h00), f(0, 1, 8'h00), 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("clr_wait_out_valid", {31'd0, out_valid}, 1);
    max_clr = 1'b1;
    @(posedge clk);
    #1 max_clr = 1'b0;
    chk("clr_hs_cnt", {16'd0, true_cnt}, 0);
    chk("clr_hs_max_valid", {31'd0, max_valid}, 0);
    drain();

    // Signed zeros
`ifdef FLOAT_CMP_ZERO_EQ_EN
    send(EQ, f(0, 0, 8'h00), f(1, 0, 8'h00), 1'b1);
`else
    send(EQ, f(0, 0, 8'h00), f(1, 0, 8'h00), 1'b0);
`endif
    drain();

    // Reset with beats in flight
    send(GT, f(0, 1, 8'h00), f(0, 2, 8'h00), 1'b0);
    send(GT, f(0, 6, 8'h00), f(0, 2, 8'h00), 1'b1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    chk("midrst_max_valid", {31'd0, max_valid}, 0);
    chk("midrst_cnt", {16'd0, true_cnt}, 0);
    repeat (10) @(posedge clk);
    #1 chk("midrst_ready_back", {31'd0, in_ready}, 1);
    chk("midrst_quiet", {31'd0, out_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
